mux_nx1_reg: RTL and testbench

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input channel and on the output. It selects one channel per cycle, either by an explicit select or by round-robin arbitration, and buffers the chosen word in a single output register. It sits in the CPU datapath wherever several producers feed one consumer, such as register-file write-back sources or bus masters. It generalises the fixed 2x1 3-bit combinational mux.

---
 rtl/mux_nx1_reg_if.sv | 29 ++
 rtl/mux_nx1_reg.sv | 137 +++++++++++++
 tb/tb_mux_nx1_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_reg_if.sv
// Handshake bundle for mux_nx1_reg: N input channels with valid/ready, select/mode
// controls, and one registered output channel with valid/ready.
// master: the surrounding logic (producers + consumer); slave: the mux itself.
interface mux_nx1_reg_if #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned N     = 4
);
   localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [SELW-1:0]    sel;
   logic               mode;
   logic [WIDTH-1:0]   out_data;
   logic [SELW-1:0]    out_chan;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_data, in_valid, sel, mode, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );

   modport slave (
      input  in_data, in_valid, sel, mode, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_nx1_reg.sv
// mux_nx1_reg: N-input, WIDTH-bit registered multiplexer with valid/ready on every
// channel. One channel is granted per cycle, either by explicit select (mode=0) or
// by round-robin arbitration (mode=1), and its word is captured in a single-entry
// output register. in_ready is combinational; in_data only reaches the register.
//
// Build option: define MUX_NX1_RR_EN to build the round-robin arbiter and rr_ptr.
// Without it, mode is ignored and fixed-select behaviour always applies.
module mux_nx1_reg #(
   parameter  int unsigned WIDTH = 3,
   parameter  int unsigned N     = 4,
   localparam int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
   input logic            clk,
   input logic            rst_n,
   mux_nx1_reg_if.slave   bus
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SELW-1:0]  out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;

   logic             load_en;
   logic [N-1:0]     grant_fixed;
   logic [N-1:0]     grant;
   logic [N-1:0]     in_ready;
   logic             xfer;
   logic [SELW-1:0]  win_idx;
   logic [WIDTH-1:0] win_data;

   // The register can take a word when empty or when its word leaves this cycle.
   assign load_en = ~out_valid_q | bus.out_ready;

   // Fixed select: sel values of N or more match no channel and grant nothing.
   always_comb begin
      grant_fixed = '0;
      for (int i = 0; i < N; i++) begin
         grant_fixed[i] = bus.in_valid[i] && (bus.sel == SELW'(i));
      end
   end

`ifdef MUX_NX1_RR_EN
   logic [SELW-1:0] rr_ptr_q;
   logic [N-1:0]    grant_rr;

   // Round-robin: first valid channel after the last winner, wrapping N-1 -> 0.
   always_comb begin
      int unsigned idx;
      logic        found;
      grant_rr = '0;
      found    = 1'b0;
      idx      = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = 32'(rr_ptr_q) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!found && bus.in_valid[SELW'(idx)]) begin
            grant_rr[SELW'(idx)] = 1'b1;
            found                = 1'b1;
         end
      end
   end

   assign grant = bus.mode ? grant_rr : grant_fixed;

   // rr_ptr tracks the last winner in both modes; reset value gives ch0 first pick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= SELW'(N - 1);
      end else if (xfer) begin
         rr_ptr_q <= win_idx;
      end
   end
`else
   logic unused_mode;

   assign unused_mode = bus.mode;
   assign grant       = grant_fixed;
`endif

   // Gated by rst_n so no producer sees ready while the block is held in reset.
   assign in_ready     = grant & {N{load_en & rst_n}};
   assign bus.in_ready = in_ready;
   assign xfer         = |in_ready;

   // Encode the one-hot grant into the winning index and its data word.
   always_comb begin
      win_idx  = '0;
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            win_idx  = SELW'(i);
            win_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Load on input transfer (replaces a draining word with no bubble), else drain.
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      if (xfer) begin
         out_data_d  = win_data;
         out_chan_d  = win_idx;
         out_valid_d = 1'b1;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Single-entry output register; async reset drops any held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_chan  = out_chan_q;
   assign bus.out_valid = out_valid_q;

   // At most one producer may be accepted per cycle.
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(in_ready));

   // A stalled word must stay put until the consumer takes it.
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q)));

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed bench for mux_nx1_reg (WIDTH=3, N=4): a fixed-mode vector table, an
// asynchronous mid-stream reset, and an arbitration sequence table whose contents
// depend on whether MUX_NX1_RR_EN is defined.
module tb_mux_nx1_reg;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mux_nx1_reg_if #(.WIDTH(3), .N(4)) bus ();

   mux_nx1_reg #(.WIDTH(3), .N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [3:0]  valid;
      logic [11:0] data;
      logic        ordy;
      logic [3:0]  exp_ready;
      logic        exp_ov;
      logic [2:0]  exp_od;
      logic [1:0]  exp_oc;
   } vec_t;

   typedef struct {
      logic [3:0] valid;
      logic       mode;
      logic [1:0] sel;
      logic [1:0] chan;
   } seq_t;

   vec_t       vecs[15];
   seq_t       seqs[11];
   logic [2:0] chd[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;

      // data packing: {ch3, ch2, ch1, ch0}
      vecs[0]  = '{1'b0, 2'd1, 4'b0010, {3'b000, 3'b000, 3'b101, 3'b000}, 1'b1,
                   4'b0010, 1'b1, 3'b101, 2'd1};
      vecs[1]  = '{1'b0, 2'd2, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b011}, 1'b1,
                   4'b0000, 1'b0, 3'b101, 2'd1};
      vecs[2]  = '{1'b0, 2'd2, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b011}, 1'b1,
                   4'b0000, 1'b0, 3'b101, 2'd1};
      vecs[3]  = '{1'b0, 2'd0, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b011}, 1'b1,
                   4'b0001, 1'b1, 3'b011, 2'd0};
      for (int i = 4; i <= 8; i++) begin
         vecs[i] = '{1'b0, 2'd3, 4'b1000, {3'b110, 3'b000, 3'b000, 3'b000}, 1'b0,
                     4'b0000, 1'b1, 3'b011, 2'd0};
      end
      vecs[9]  = '{1'b0, 2'd3, 4'b1000, {3'b110, 3'b000, 3'b000, 3'b000}, 1'b1,
                   4'b1000, 1'b1, 3'b110, 2'd3};
      vecs[10] = '{1'b0, 2'd3, 4'b0000, 12'h000, 1'b1,
                   4'b0000, 1'b0, 3'b110, 2'd3};
      vecs[11] = '{1'b0, 2'd2, 4'b0100, {3'b000, 3'b111, 3'b000, 3'b000}, 1'b0,
                   4'b0100, 1'b1, 3'b111, 2'd2};
      vecs[12] = '{1'b0, 2'd2, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 1'b0,
                   4'b0000, 1'b1, 3'b111, 2'd2};
      vecs[13] = '{1'b0, 2'd2, 4'b0100, {3'b000, 3'b010, 3'b000, 3'b000}, 1'b1,
                   4'b0100, 1'b1, 3'b010, 2'd2};
      vecs[14] = '{1'b0, 2'd3, 4'b1111, {3'b111, 3'b100, 3'b010, 3'b001}, 1'b1,
                   4'b1000, 1'b1, 3'b111, 2'd3};

      chd[0] = 3'b001;
      chd[1] = 3'b010;
      chd[2] = 3'b100;
      chd[3] = 3'b111;

`ifdef MUX_NX1_RR_EN
      // Fairness from reset, then ch1/ch3 alternation, fixed sel=3, back to RR.
      seqs[0]  = '{4'b1111, 1'b1, 2'd0, 2'd0};
      seqs[1]  = '{4'b1111, 1'b1, 2'd0, 2'd1};
      seqs[2]  = '{4'b1111, 1'b1, 2'd0, 2'd2};
      seqs[3]  = '{4'b1111, 1'b1, 2'd0, 2'd3};
      seqs[4]  = '{4'b1111, 1'b1, 2'd0, 2'd0};
      seqs[5]  = '{4'b1111, 1'b1, 2'd0, 2'd1};
      seqs[6]  = '{4'b1010, 1'b1, 2'd0, 2'd3};
      seqs[7]  = '{4'b1010, 1'b1, 2'd0, 2'd1};
      seqs[8]  = '{4'b1010, 1'b0, 2'd3, 2'd3};
      seqs[9]  = '{4'b1010, 1'b0, 2'd3, 2'd3};
      seqs[10] = '{4'b1010, 1'b1, 2'd0, 2'd1};
`else
      // Without the arbiter, mode is ignored and sel always decides.
      seqs[0]  = '{4'b1111, 1'b1, 2'd2, 2'd2};
      seqs[1]  = '{4'b1111, 1'b1, 2'd2, 2'd2};
      seqs[2]  = '{4'b1111, 1'b1, 2'd2, 2'd2};
      seqs[3]  = '{4'b1111, 1'b1, 2'd0, 2'd0};
      seqs[4]  = '{4'b1111, 1'b1, 2'd3, 2'd3};
      seqs[5]  = '{4'b1111, 1'b0, 2'd1, 2'd1};
      seqs[6]  = '{4'b1010, 1'b1, 2'd1, 2'd1};
      seqs[7]  = '{4'b1010, 1'b1, 2'd3, 2'd3};
      seqs[8]  = '{4'b1010, 1'b1, 2'd3, 2'd3};
      seqs[9]  = '{4'b1010, 1'b0, 2'd1, 2'd1};
      seqs[10] = '{4'b1010, 1'b1, 2'd3, 2'd3};
`endif

      rst_n         = 1'b0;
      bus.in_data   = '0;
      bus.in_valid  = '0;
      bus.sel       = '0;
      bus.mode      = 1'b0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_data", 32'(bus.out_data), 32'd0);
      check("reset out_chan", 32'(bus.out_chan), 32'd0);
      check("reset in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         bus.mode      = vecs[i].mode;
         bus.sel       = vecs[i].sel;
         bus.in_valid  = vecs[i].valid;
         bus.in_data   = vecs[i].data;
         bus.out_ready = vecs[i].ordy;
         #1;
         check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
         check($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_od));
         check($sformatf("v%0d out_chan", i), 32'(bus.out_chan), 32'(vecs[i].exp_oc));
      end

      // Mid-stream reset while a word is held: cleared without waiting for a clock.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst out_data", 32'(bus.out_data), 32'd0);
      check("midrst out_chan", 32'(bus.out_chan), 32'd0);
      check("midrst in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      bus.in_data   = {chd[3], chd[2], chd[1], chd[0]};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         logic [3:0] exp_rdy;
         exp_rdy      = 4'(1 << seqs[i].chan);
         bus.in_valid = seqs[i].valid;
         bus.mode     = seqs[i].mode;
         bus.sel      = seqs[i].sel;
         #1;
         check($sformatf("s%0d in_ready", i), 32'(bus.in_ready), 32'(exp_rdy));
         @(posedge clk);
         #1;
         check($sformatf("s%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("s%0d out_chan", i), 32'(bus.out_chan), 32'(seqs[i].chan));
         check($sformatf("s%0d out_data", i), 32'(bus.out_data), 32'(chd[seqs[i].chan]));
      end

      // Drain with no producers left.
      bus.in_valid = '0;
      #1;
      check("drain in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("drain out_valid", 32'(bus.out_valid), 32'd0);
      check("drain out_data hold", 32'(bus.out_data), 32'(chd[seqs[10].chan]));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
